uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter the CPU writes bytes into, the transmit counterpart to the receive path used for program loading. It sits on the CPU data bus next to the LED and switch drivers, decoding `write_direction`. Bytes are queued in a small FIFO and serialized as 8N1 frames on a dedicated `tx` line. A status word is readable on the same bus.

## Interface
- `CLKS_PER_BIT`, 10417: `clk` cycles per UART bit (100 MHz / 9600 baud); legal range ≥ 2.
- `DATA_ADDR`, 32'd12: write address; `data_out[7:0]` is queued for transmission.
- `STATUS_ADDR`, 32'd16: status read address; any write here clears `overflow`.
- `FIFO_DEPTH`, 8: queue depth in bytes; legal range 2..15.
- `clk` in 1: system clock. One clock drives the whole block.
- `reset` in 1: asynchronous reset, active-low.
- `MemWrite` in 2: CPU store size; 2'b00 means no store, any nonzero value means store.
- `write_direction` in 32: CPU data address, used for both store and read decode.
- `data_out` in 32: CPU store data; only bits [7:0] are used.
- `status_out` out 32: status word when `write_direction == STATUS_ADDR`, else 32'd0. Combinational; it is ORed onto the CPU read bus.
- `tx` out 1: serial output, idle high.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.

## Operation
- **Store qualifier** `wq = (MemWrite != 0) && (write_direction == DATA_ADDR)`.
  - The CPU runs on a slower clock, so `wq` can stay high for many `clk` cycles.
  - A push happens only on the rising edge of `wq`: `wq && !wq_d`, where `wq_d` is `wq` registered.
- **Push:** when `count < FIFO_DEPTH`, write `data_out[7:0]` and increment `count`. When full, drop the byte and set the sticky `overflow`.
  - The full check uses `count` from before any same-cycle pop. A push to a full FIFO is rejected even if a pop happens in the same cycle.
- **Overflow clear:** the rising edge of `(MemWrite != 0) && (write_direction == STATUS_ADDR)` clears `overflow`. If a set and a clear land in the same cycle, set wins.
- **FIFO:** circular buffer with read and write pointers mod `FIFO_DEPTH`. Pointers wrap from `FIFO_DEPTH-1` to 0. A push and a pop in the same cycle leave `count` unchanged.
- **Transmit FSM:** states IDLE, START, DATA, STOP, with a baud counter `bc` and a bit index `bi` (0..7).
  - IDLE: `tx=1`. If `count != 0`, pop into the shift register, load `bc=0`, go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA with `bi=0`.
  - DATA: `tx = shift[bi]`, LSB first. Each bit lasts `CLKS_PER_BIT` cycles. After `bi==7` completes, go to STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles. Then, if `count != 0`, pop and go straight to START with no idle gap; otherwise go to IDLE.
- **`tx` is registered** and driven from the state and shift register. It never glitches.
- **Status word:**
  - bit0 `busy`
  - bit1 full
  - bit2 empty
  - bit3 overflow
  - bits[11:8] `count`
  - all other bits 0
- **`busy` definition:** `busy = (state != IDLE) || (count != 0)`.

## Timing
- **Reset values:** `tx=1`, `busy=0`, `overflow=0`, `count=0`, both pointers 0, state IDLE, `wq_d=0`.
  - `status_out` then reads 32'h4 when addressed (empty set).
- **Asserting `reset` mid-frame** aborts the frame immediately and returns `tx` to 1 asynchronously. All queued bytes are discarded.
- **Push latency:** the byte enters the FIFO at the `clk` edge E0 where `wq && !wq_d` is sampled.
- **Start latency:** with the FSM in IDLE, the FSM pops at E1 and `tx` falls after E1, one cycle after the push.
- **Frame length:** exactly `10*CLKS_PER_BIT` cycles from the `tx` falling edge to the end of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle right after the last stop-bit cycle.
- **Status timing:** `status_out` reflects registered state, so a push at E0 is visible in `count` after E0.

## Test plan
Use `CLKS_PER_BIT=4` and `FIFO_DEPTH=4`.
- **Reset defaults:** assert `reset=0`, then release. Expect `tx=1`, `busy=0`. With `write_direction=16`, expect `status_out=32'h4`.
- **Single byte:** one store of 8'hA5 to address 12, with `MemWrite` held for 20 cycles.
  - Expect exactly one frame, with `tx` low one cycle after the push.
  - Expect bit pattern 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles long.
  - Expect `busy` to drop after 40 cycles, and no second frame.
- **Back-to-back:** stores of 8'h01, 8'h02, 8'h03 in quick succession.
  - Expect three contiguous 40-cycle frames with no idle cycles between them.
  - Expect `count` to decrement as each frame starts.
- **Overflow:** while the first frame is sending, push 6 bytes (FIFO fills at 4 with one byte in flight).
  - Expect the extra bytes dropped and status bit3=1.
  - Expect exactly 5 frames in push order.
  - A store to address 16 then clears bit3.
- **Wrap-around:** push and drain 10 bytes in two bursts of 4 and 6, crossing the pointer wrap. Expect transmitted bytes to match in order.
- **Reset mid-frame:** assert `reset` during DATA bit 3. Expect `tx=1` immediately, `count=0`, and no frame after release.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores are queued in a small FIFO and
// shifted out on tx; a status word (busy/full/empty/overflow/count) is readable on the bus.
//
// state | meaning
// IDLE  | line idle (tx=1), waiting for a queued byte
// START | start bit (tx=0) for CLKS_PER_BIT cycles
// DATA  | data bits, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (tx=1); chains straight into START when the FIFO is non-empty
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [31:0] DATA_ADDR    = 32'd12,
    parameter logic [31:0] STATUS_ADDR  = 32'd16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] write_direction,
    input  logic [31:0] data_out,
    output logic [31:0] status_out,
    output logic        tx,
    output logic        busy
);

    localparam int              BC_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BC_W-1:0] BC_LOAD  = BC_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      DEPTH_C  = 4'(FIFO_DEPTH);
    localparam logic [3:0]      LAST_PTR = 4'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BC_W-1:0] bc, bc_n;
    logic [2:0]      bi, bi_n;
    logic [7:0]      shift, shift_n;
    logic            tx_n;

    logic            wq, wq_d, sq, sq_d;
    logic            push_rise, clr_rise;
    logic            push, pop, full, empty;
    logic            overflow;
    logic [3:0]      count, wr_ptr, rd_ptr;
    logic [7:0]      mem [16];
    logic            unused_data_bits;

    assign unused_data_bits = ^data_out[31:8];

    // The CPU clock is slower, so stores are edge-detected to push exactly once.
    assign wq        = (MemWrite != 2'b00) && (write_direction == DATA_ADDR);
    assign sq        = (MemWrite != 2'b00) && (write_direction == STATUS_ADDR);
    assign push_rise = wq && !wq_d;
    assign clr_rise  = sq && !sq_d;

    assign full  = (count == DEPTH_C);
    assign empty = (count == 4'd0);
    assign push  = push_rise && !full;
    assign busy  = (state != IDLE) || !empty;

    assign status_out = (write_direction == STATUS_ADDR) ?
                        {20'd0, count, 4'd0, overflow, empty, full, busy} : 32'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_out[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wq_d     <= 1'b0;
            sq_d     <= 1'b0;
            count    <= 4'd0;
            wr_ptr   <= 4'd0;
            rd_ptr   <= 4'd0;
            overflow <= 1'b0;
        end else begin
            wq_d  <= wq;
            sq_d  <= sq;
            count <= count + {3'd0, push} - {3'd0, pop};
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? 4'd0 : wr_ptr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? 4'd0 : rd_ptr + 4'd1;
            end
            // A rejected push and a clear in the same cycle leave overflow set.
            if (push_rise && full) begin
                overflow <= 1'b1;
            end else if (clr_rise) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bc    <= '0;
            bi    <= 3'd0;
            shift <= 8'd0;
            tx    <= 1'b1;
        end else begin
            state <= state_n;
            bc    <= bc_n;
            bi    <= bi_n;
            shift <= shift_n;
            tx    <= tx_n;
        end
    end

    always_comb begin
        state_n = state;
        bc_n    = bc;
        bi_n    = bi;
        shift_n = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    bc_n    = BC_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (bc == '0) begin
                    bc_n    = BC_LOAD;
                    bi_n    = 3'd0;
                    state_n = DATA;
                end else begin
                    bc_n = bc - 1'b1;
                end
            end
            DATA: begin
                if (bc == '0) begin
                    bc_n = BC_LOAD;
                    if (bi == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bi_n = bi + 3'd1;
                    end
                end else begin
                    bc_n = bc - 1'b1;
                end
            end
            STOP: begin
                if (bc == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        bc_n    = BC_LOAD;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bc_n = bc - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next state so it lines up with the state register.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[bi_n];
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: a byte-queue model predicts accepted bytes,
// overflow and status; a monitor decodes tx frames and checks busy/status every cycle.
module tb_uart_tx_mmio;

    localparam int          CPB     = 4;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] D_ADDR  = 32'd12;
    localparam logic [31:0] S_ADDR  = 32'd16;
    localparam int          FRAME   = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  MemWrite = 2'b00;
    logic [31:0] write_direction = S_ADDR;
    logic [31:0] data_out = 32'd0;
    logic [31:0] status_out;
    logic        tx;
    logic        busy;

    uart_tx_mmio #(
        .CLKS_PER_BIT (CPB),
        .DATA_ADDR    (D_ADDR),
        .STATUS_ADDR  (S_ADDR),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .MemWrite        (MemWrite),
        .write_direction (write_direction),
        .data_out        (data_out),
        .status_out      (status_out),
        .tx              (tx),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         acc      = 0;
    int         started  = 0;
    logic       ovf_m    = 1'b0;

    logic       in_frame = 1'b0;
    logic       chk_next = 1'b0;
    logic       exp_b2b  = 1'b0;
    int         pos      = 0;
    logic       smp [FRAME];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_frame();
        logic [63:0] gw;
        logic [63:0] ew;
        logic [9:0]  bits;
        logic [7:0]  b;
        gw = '0;
        ew = '0;
        for (int i = 0; i < FRAME; i++) gw[i] = smp[i];
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame: got unexpected frame %h, expected no frame", gw[39:0]);
        end else begin
            b    = exp_q.pop_front();
            bits = {1'b1, b, 1'b0};
            for (int i = 0; i < FRAME; i++) ew[i] = bits[i / CPB];
            chk("frame", gw, ew);
        end
    endtask

    // Monitor: samples 1ns after each rising edge.
    initial begin
        int          occ;
        logic        bexp;
        logic [31:0] sexp;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                in_frame = 1'b0;
                chk_next = 1'b0;
                pos      = 0;
            end else begin
                if (chk_next) begin
                    chk_next = 1'b0;
                    chk("b2b_gap", tx, exp_b2b ? 64'd0 : 64'd1);
                end
                if (!in_frame && tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    started++;
                end
                occ  = acc - started;
                bexp = in_frame || (occ != 0);
                chk("busy", busy, bexp);
                sexp = (write_direction == S_ADDR) ?
                       {20'd0, 4'(occ), 4'd0, ovf_m, (occ == 0), (occ == DEPTH), bexp} : 32'd0;
                chk("status", status_out, sexp);
                if (in_frame) begin
                    smp[pos] = tx;
                    pos++;
                    if (pos == FRAME) begin
                        check_frame();
                        in_frame = 1'b0;
                        exp_b2b  = (acc - started) > 0;
                        chk_next = 1'b1;
                    end
                end
            end
        end
    end

    // Called on a falling edge; returns on a falling edge with the bus parked on status.
    task automatic store(input logic [31:0] addr, input logic [7:0] b, input int hold);
        MemWrite        = 2'($urandom_range(1, 3));
        write_direction = addr;
        data_out        = {24'($urandom), b};
        if (addr == D_ADDR) begin
            if (acc - started < DEPTH) begin
                exp_q.push_back(b);
                acc++;
            end else begin
                ovf_m = 1'b1;
            end
        end else if (addr == S_ADDR) begin
            ovf_m = 1'b0;
        end
        repeat (hold) @(negedge clk);
        MemWrite        = 2'b00;
        write_direction = S_ADDR;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", t < limit, 1);
        @(negedge clk);
    endtask

    task automatic wait_room(input int limit);
        int t;
        t = 0;
        while ((acc - started) >= DEPTH && t < limit) begin
            @(negedge clk);
            t++;
        end
        chk("room_timeout", t < limit, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_status", status_out, 32'h4);
        @(negedge clk);

        // Single byte, store held for many cycles.
        MemWrite        = 2'b01;
        write_direction = D_ADDR;
        data_out        = 32'hFFFF_FFA5;
        exp_q.push_back(8'hA5);
        acc++;
        @(posedge clk);
        #2;
        chk("start_lat_e0", tx, 1);
        @(posedge clk);
        #2;
        chk("start_lat_e1", tx, 0);
        repeat (19) @(negedge clk);
        MemWrite        = 2'b00;
        write_direction = S_ADDR;
        repeat (21) @(posedge clk);
        #2;
        chk("busy_last_stop", busy, 1);
        @(posedge clk);
        #2;
        chk("busy_after_frame", busy, 0);
        chk("tx_after_frame", tx, 1);
        @(negedge clk);
        wait_idle(200);

        // Back-to-back frames.
        store(D_ADDR, 8'h01, 1);
        store(D_ADDR, 8'h02, 1);
        store(D_ADDR, 8'h03, 1);
        wait_idle(400);

        // Overflow: one byte in flight, four queued, two dropped.
        store(D_ADDR, 8'h10, 1);
        for (int i = 0; i < 6; i++) store(D_ADDR, 8'(8'h20 + i), 1);
        @(posedge clk);
        #2;
        chk("ovf_set", status_out[3], 1);
        @(negedge clk);
        store(S_ADDR, 8'h00, 1);
        @(posedge clk);
        #2;
        chk("ovf_clear", status_out[3], 0);
        @(negedge clk);
        wait_idle(600);

        // Wrap-around: bursts of 4 and 6, pushing only when there is room.
        for (int i = 0; i < 4; i++) store(D_ADDR, 8'($urandom), 1);
        wait_idle(600);
        for (int i = 0; i < 6; i++) begin
            wait_room(200);
            store(D_ADDR, 8'($urandom), 1);
        end
        wait_idle(800);

        // Random mix of stores, status clears, idle time and non-pushing accesses.
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                store(D_ADDR, 8'($urandom), $urandom_range(1, 4));
            end else if (op == 6) begin
                store(S_ADDR, 8'($urandom), $urandom_range(1, 3));
            end else if (op == 7) begin
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end else if (op == 8) begin
                write_direction = D_ADDR;
                data_out        = $urandom;
                repeat (3) @(negedge clk);
                write_direction = S_ADDR;
                @(negedge clk);
            end else begin
                store(32'd20, 8'($urandom), 2);
            end
        end
        wait_idle(2000);

        // Reset during data bit 3 with bytes still queued.
        store(D_ADDR, 8'hC3, 1);
        store(D_ADDR, 8'h5A, 1);
        store(D_ADDR, 8'h7E, 1);
        t = 0;
        while (!(in_frame && pos == 4 * CPB + 1) && t < 200) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("reach_bit3_timeout", t < 200, 1);
        #1;
        reset = 1'b0;
        exp_q.delete();
        acc     = 0;
        started = 0;
        ovf_m   = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_status", status_out, 32'h4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_frame_after_reset", started, 0);
        chk("tx_idle_after_reset", tx, 1);

        wait_idle(200);
        chk("all_frames_seen", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
